// File: rtl/sap1_pkg.sv
// rtl/sap1_pkg.sv - SAP-1 sequencer constants: opcodes, control bit indices, widths
package sap1_pkg;

  localparam int NUM_TSTATES  = 6;
  localparam int OPCODE_WIDTH = 4;
  localparam int CW_WIDTH     = 12;

  localparam logic [OPCODE_WIDTH-1:0] OP_LDA = 4'b0000;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 4'b0001;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = 4'b0010;
  localparam logic [OPCODE_WIDTH-1:0] OP_OUT = 4'b1110;
  localparam logic [OPCODE_WIDTH-1:0] OP_HLT = 4'b1111;

  localparam int CW_CP = 11;
  localparam int CW_EP = 10;
  localparam int CW_LM = 9;
  localparam int CW_CE = 8;
  localparam int CW_LI = 7;
  localparam int CW_EI = 6;
  localparam int CW_LA = 5;
  localparam int CW_EA = 4;
  localparam int CW_SU = 3;
  localparam int CW_EU = 2;
  localparam int CW_LB = 1;
  localparam int CW_LO = 0;

endpackage

// File: rtl/ring_counter.sv
// rtl/ring_counter.sv - one-hot T-state ring, resets to bit0, rotates when advanced
module ring_counter #(
  parameter int N = 6
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         advance_i,
  output logic [N-1:0] state_o
);

  logic [N-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (advance_i) state_d = {state_q[N-2:0], state_q[N-1]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= {{(N-1){1'b0}}, 1'b1};
    else       state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/controller_sequencer.sv
// rtl/controller_sequencer.sv - SAP-1 control unit: T-state ring plus opcode decode and halt
module controller_sequencer
  import sap1_pkg::*;
#(
  parameter int NUM_TSTATES_P  = NUM_TSTATES,
  parameter int OPCODE_WIDTH_P = OPCODE_WIDTH,
  parameter int CW_WIDTH_P     = CW_WIDTH
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_debug,
  input  logic                      i_run,
  input  logic [OPCODE_WIDTH_P-1:0] i_opcode,
  output logic [NUM_TSTATES_P-1:0]  o_tstate,
  output logic [CW_WIDTH_P-1:0]     o_control_word,
  output logic                      o_halt
);

  logic                  halt_q, halt_d;
  logic                  halt_now;
  logic                  advance;
  logic [CW_WIDTH_P-1:0] cw_raw;
  logic                  unused_debug;

  // Trace enable has no hardware meaning.
  assign unused_debug = i_debug;

  assign o_halt  = halt_q | halt_now;
  assign advance = i_run & ~o_halt;
  assign halt_d  = o_halt;

  ring_counter #(.N(NUM_TSTATES_P)) u_ring (
    .clk_i     (i_clock),
    .rst_i     (i_reset),
    .advance_i (advance),
    .state_o   (o_tstate)
  );

  always_comb begin
    cw_raw   = '0;
    halt_now = 1'b0;
    if (o_tstate[0]) begin
      cw_raw[CW_EP] = 1'b1;
      cw_raw[CW_LM] = 1'b1;
    end
    if (o_tstate[1]) cw_raw[CW_CP] = 1'b1;
    if (o_tstate[2]) begin
      cw_raw[CW_CE] = 1'b1;
      cw_raw[CW_LI] = 1'b1;
    end
    if (o_tstate[3]) begin
      case (i_opcode)
        OP_LDA, OP_ADD, OP_SUB: begin
          cw_raw[CW_EI] = 1'b1;
          cw_raw[CW_LM] = 1'b1;
        end
        OP_OUT: begin
          cw_raw[CW_EA] = 1'b1;
          cw_raw[CW_LO] = 1'b1;
        end
        OP_HLT:  halt_now = 1'b1;
        default: ;
      endcase
    end
    if (o_tstate[4]) begin
      case (i_opcode)
        OP_LDA: begin
          cw_raw[CW_CE] = 1'b1;
          cw_raw[CW_LA] = 1'b1;
        end
        OP_ADD, OP_SUB: begin
          cw_raw[CW_CE] = 1'b1;
          cw_raw[CW_LB] = 1'b1;
        end
        default: ;
      endcase
    end
    if (o_tstate[5]) begin
      case (i_opcode)
        OP_ADD: begin
          cw_raw[CW_EU] = 1'b1;
          cw_raw[CW_LA] = 1'b1;
        end
        OP_SUB: begin
          cw_raw[CW_SU] = 1'b1;
          cw_raw[CW_EU] = 1'b1;
          cw_raw[CW_LA] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Reset, pause and halt all gate the word so no register is re-clocked.
  assign o_control_word = (i_reset || !i_run || o_halt) ? '0 : cw_raw;

  always_ff @(posedge i_clock) begin
    if (i_reset) halt_q <= 1'b0;
    else         halt_q <= halt_d;
  end

endmodule
